// File: rtl/reg_file_mp.sv
// Parametrised register file: two prioritised write ports, two combinational
// read ports with optional write-to-read bypass, and a one-entry-per-cycle clear engine.
module reg_file_mp #(
  parameter int DW     = 8,
  parameter int AW     = 3,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          busy,
  input  logic          wr0_en,
  input  logic [AW-1:0] wr0_addr,
  input  logic [DW-1:0] wr0_data,
  input  logic          wr1_en,
  input  logic [AW-1:0] wr1_addr,
  input  logic [DW-1:0] wr1_data,
  input  logic [AW-1:0] rd_addrA,
  input  logic [AW-1:0] rd_addrB,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic          wr_drop
);

  localparam int unsigned DEPTH = 2**AW;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          collide;
  logic          drop;
  logic          byp_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (ptr == AW'(DEPTH - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  // ptr wraps back to 0 on the edge that clears the last entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              ptr <= '0;
    else if (state == CLEAR) ptr <= ptr + 1'b1;
  end

  assign collide = wr0_en && wr1_en && (wr0_addr == wr1_addr);
  assign drop    = busy ? (wr0_en || wr1_en) : collide;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i[AW-1:0]] <= '0;
    end else if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else begin
      if (wr0_en)             mem[wr0_addr] <= wr0_data;
      if (wr1_en && !collide) mem[wr1_addr] <= wr1_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_drop <= 1'b0;
    else        wr_drop <= drop;
  end

  // Bypass priority mirrors the commit priority so forwarded data equals stored data
  assign byp_en = (BYPASS != 0) && !busy;

  always_comb begin
    datA_out = mem[rd_addrA];
    if (byp_en) begin
      if (wr0_en && (rd_addrA == wr0_addr))      datA_out = wr0_data;
      else if (wr1_en && (rd_addrA == wr1_addr)) datA_out = wr1_data;
    end
  end

  always_comb begin
    datB_out = mem[rd_addrB];
    if (byp_en) begin
      if (wr0_en && (rd_addrB == wr0_addr))      datB_out = wr0_data;
      else if (wr1_en && (rd_addrB == wr1_addr)) datB_out = wr1_data;
    end
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-write-port register file; next-generation replacement for the 8-wide, 8-deep single-write-port register file in the datapath.
- Provides two write ports with fixed priority and two combinational read ports.
- Optional write-to-read bypass.
- Sequenced bulk-clear engine that zeroes the array one entry per cycle, so software-initiated clears need no reset.

Parameters:
DW, 8, data width of each register in bits
AW, 3, address width; depth = 2**AW entries
BYPASS, 1, 1 = read port returns same-cycle write data on address match; 0 = reads return stored contents only

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
clr_req  input  1  request bulk clear of all entries (sampled in IDLE only)
busy  output  1  high while the clear engine is running
wr0_en  input  1  write enable, port 0 (high priority)
wr0_addr  input  AW  write address, port 0
wr0_data  input  DW  write data, port 0
wr1_en  input  1  write enable, port 1 (low priority)
wr1_addr  input  AW  write address, port 1
wr1_data  input  DW  write data, port 1
rd_addrA  input  AW  read address A
rd_addrB  input  AW  read address B
datA_out  output  DW  read data A
datB_out  output  DW  read data B
wr_drop  output  1  registered one-cycle pulse: a requested write was discarded in the previous cycle

Behaviour:
- Reset (reset=0, asynchronous):
  - all entries become 0; FSM goes to IDLE; clear pointer goes to 0.
  - busy=0, wr_drop=0; datA_out/datB_out read 0.
  - Deassertion takes effect at the next rising edge.
- FSM states are IDLE and CLEAR.
  - IDLE to CLEAR: on the edge where clr_req=1. busy rises in the same edge.
  - CLEAR: each edge writes 0 to entry[ptr], then ptr increments.
  - On the edge that writes entry[2**AW-1]: go to IDLE, ptr returns to 0, busy falls.
  - busy is high for exactly 2**AW cycles.
  - clr_req while in CLEAR is ignored; it does not restart or extend the clear.
- Writes in IDLE, applied on the rising edge:
  - wr0_en=1 writes wr0_data to entry[wr0_addr].
  - wr1_en=1 writes wr1_data to entry[wr1_addr].
  - Different addresses: both writes commit in the same edge.
  - Same address with both enabled: port 0 wins, port 1 is discarded, wr_drop=1 on the next cycle.
- Writes in CLEAR (busy=1): every enabled write is discarded; wr_drop=1 on the next cycle for each such cycle.
- wr_drop:
  - Registered: high during cycle N+1 only if a discard occurred in cycle N; otherwise 0.
  - Not sticky; no clear input needed.
- Reads are combinational from the array.
- BYPASS=1 and busy=0:
  - If rd_addrX matches wr0_addr with wr0_en=1, output wr0_data.
  - Otherwise, if it matches wr1_addr with wr1_en=1, output wr1_data.
  - Otherwise, output stored contents.
  - Bypass obeys the same priority as the write commit, so the bypassed value always equals the committed value.
- Bypass is inhibited while busy=1; reads return stored contents, including partially cleared state.
- BYPASS=0: reads always return stored contents; new data is visible the cycle after the write edge.
- Addresses are full-range for depth 2**AW; no out-of-range case exists.
- Reset asserted mid-CLEAR: immediate return to IDLE with all entries 0; no residual busy.
- Simultaneous clr_req and writes in IDLE: the writes commit on that edge and clear starts on the same edge.
  - ptr 0 clears on the following edge, so an entry written on the request edge is still zeroed during the sweep.

Test Plan:
- Reset then read: pulse reset low mid-cycle with DW=8, AW=3 → datA_out=datB_out=0 immediately, busy=0, wr_drop=0.
- Dual write, distinct addresses: wr0 (addr 2, 0xA5) and wr1 (addr 5, 0x3C) in the same cycle → next cycle rd A=2 gives 0xA5, rd B=5 gives 0x3C, wr_drop=0.
- Collision: wr0 (addr 4, 0x11) and wr1 (addr 4, 0x22) in the same cycle → entry4=0x11 and wr_drop=1 for exactly one cycle. With BYPASS=1 and rd_addrA=4 in that cycle, datA_out=0x11 combinationally.
- Bulk clear: fill entries 0..7 with 0xFF, then pulse clr_req for one cycle:
  - busy is high for exactly 8 cycles.
  - Entry k reads 0 starting k+1 edges after the request edge.
  - All entries read 0 after busy falls.
- Write during clear: wr0 (addr 1, 0x77) issued while busy=1 → entry1 stays 0 after the clear, wr_drop=1 the next cycle, no bypass of 0x77 on datA_out.
- Reset mid-clear: assert reset at the 3rd busy cycle, then release → busy=0, all entries 0, a new clr_req runs the full 8 cycles.
